counter_cmd_sequencer: RTL

Sequencing controller for the LED/7-segment counter datapath. It takes the four raw board switches, synchronizes and debounces them, and arbitrates between manual steps, clears and a periodic auto-run tick. The result is single-cycle command pulses, `o_Step` and `o_Clear`, that drive the counter's increment and reset inputs. It sits between the board pins and the counter so that no switch edge reaches the datapath undebounced.

---
 rtl/counter_ctrl_pkg.sv | 23 ++
 rtl/switch_debounce.sv | 58 +++++
 rtl/counter_cmd_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and timing defaults for the counter control path.
// Defaults are derived from the board clock so they track a clock change.
package counter_ctrl_pkg;

   localparam int unsigned CLK_FREQ_HZ         = 25_000_000;
   localparam int unsigned DEBOUNCE_MS         = 10;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
   localparam int unsigned AUTO_PERIOD_DEF     = CLK_FREQ_HZ;

   // Switch lanes, in board order
   localparam int unsigned NUM_SW   = 4;
   localparam int unsigned SW_STEP  = 0;
   localparam int unsigned SW_AUTO  = 1;
   localparam int unsigned SW_CLEAR = 2;
   localparam int unsigned SW_HOLD  = 3;

   typedef enum logic [1:0] {
      MANUAL    = 2'd0,
      AUTO_RUN  = 2'd1,
      AUTO_HOLD = 2'd2
   } seq_state_e;

endpackage

// File: rtl/switch_debounce.sv
// One switch front end: 2-FF synchronizer, stable-level debounce counter and
// a single-cycle press pulse on every accepted rising level.
module switch_debounce
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Raw,
   output logic o_Level,
   output logic o_Press
);

   localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          level_dly_q;
   logic          press_q, press_d;

   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      // The flip happens on the DEBOUNCE_CYCLES-th disagreeing sample, so the
      // stored count tops out one below the terminal value.
      if (sync_q[1] != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press_d = level_q & ~level_dly_q;
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], i_Raw};
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= press_d;
      end
   end

   assign o_Level = level_q;
   assign o_Press = press_q;

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Turns debounced board switches into single-cycle step/clear commands for the
// counter, with manual stepping and a holdable periodic auto-run mode.
module counter_cmd_sequencer
   import counter_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned AUTO_PERIOD     = AUTO_PERIOD_DEF
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Switch_1,
   input  logic i_Switch_2,
   input  logic i_Switch_3,
   input  logic i_Switch_4,
   output logic o_Step,
   output logic o_Clear,
   output logic o_Auto_Mode,
   output logic o_Hold
);

   localparam int unsigned   TW         = $clog2(AUTO_PERIOD);
   localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);

   logic [NUM_SW-1:0] sw_raw;
   logic [NUM_SW-1:0] sw_press;
   logic [NUM_SW-1:0] sw_level_unused;

   assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

   generate
      for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
         switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_db (
            .i_Clk   (i_Clk),
            .i_Rst   (i_Rst),
            .i_Raw   (sw_raw[g]),
            .o_Level (sw_level_unused[g]),
            .o_Press (sw_press[g])
         );
      end
   endgenerate

   seq_state_e    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          step_q, step_d;
   logic          clear_q, clear_d;
   logic          auto_q, auto_d;
   logic          hold_q, hold_d;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      step_d  = 1'b0;
      clear_d = 1'b0;
      unique case (state_q)
         MANUAL: begin
            if (sw_press[SW_AUTO]) begin
               state_d = AUTO_RUN;
               timer_d = '0;
            end else if (sw_press[SW_STEP]) begin
               step_d = 1'b1;
            end
         end
         AUTO_RUN: begin
            // Leaving auto-run swallows a coincident tick.
            if (sw_press[SW_AUTO]) begin
               state_d = MANUAL;
            end else begin
               if (timer_q == TIMER_LAST) begin
                  timer_d = '0;
                  step_d  = 1'b1;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
               if (sw_press[SW_HOLD]) state_d = AUTO_HOLD;
            end
         end
         AUTO_HOLD: begin
            if (sw_press[SW_AUTO])      state_d = MANUAL;
            else if (sw_press[SW_HOLD]) state_d = AUTO_RUN;
         end
         default: state_d = MANUAL;
      endcase
      // Clear drops rather than defers any step in the same cycle.
      if (sw_press[SW_CLEAR]) begin
         clear_d = 1'b1;
         step_d  = 1'b0;
         timer_d = '0;
      end
      auto_d = (state_d != MANUAL);
      hold_d = (state_d == AUTO_HOLD);
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state_q <= MANUAL;
         timer_q <= '0;
         step_q  <= 1'b0;
         clear_q <= 1'b0;
         auto_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         step_q  <= step_d;
         clear_q <= clear_d;
         auto_q  <= auto_d;
         hold_q  <= hold_d;
      end
   end

   assign o_Step      = step_q;
   assign o_Clear     = clear_q;
   assign o_Auto_Mode = auto_q;
   assign o_Hold      = hold_q;

endmodule
